// File: rtl/column_buffer_scheduler.sv
// column_buffer_scheduler: double-buffered CPU->GPU column store, banks swap on v_sync fall after commit.
// Optional COLUMN_BUFFER_CLEAR_ON_SWAP_EN refills the new back bank with "no wall" after every swap.
module column_buffer_scheduler #(
  parameter int COLUMNS = 320,
  parameter int IDX_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cpu_wr_req,
  input  logic [IDX_W-1:0]  cpu_wr_index,
  input  logic [DATA_W-1:0] cpu_wr_distance,
  input  logic [DATA_W-1:0] cpu_wr_texture,
  output logic              cpu_wr_ack,
  input  logic              cpu_commit,
  output logic              swap_pending,
  output logic              wr_error,
  input  logic              v_sync,
  input  logic [IDX_W-1:0]  gpu_read_index,
  output logic [DATA_W-1:0] gpu_distance,
  output logic [DATA_W-1:0] gpu_texture,
  output logic              front_sel,
  output logic [7:0]        frame_count
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(COLUMNS - 1);
  typedef enum logic [1:0] {
    ACCEPT,
    SWAP_PENDING
`ifdef COLUMN_BUFFER_CLEAR_ON_SWAP_EN
    , CLEARING
`endif
  } state_t;
`ifdef COLUMN_BUFFER_CLEAR_ON_SWAP_EN
  localparam state_t RST_ST = CLEARING;
  localparam state_t POST_SWAP = CLEARING;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
`else
  localparam state_t RST_ST = ACCEPT;
  localparam state_t POST_SWAP = ACCEPT;
`endif
  state_t state_q, state_d;
  logic front_sel_q, front_sel_d;
  logic ack_q, ack_d;
  logic wr_error_q, wr_error_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic vs_prev_q;
  logic [2*DATA_W-1:0] rd_q, rd_d;
  logic [2*DATA_W-1:0] mem [2][COLUMNS];
  logic wr_en, wr_ok, in_range, vs_fall;
  logic [IDX_W-1:0] wr_idx;
  logic [2*DATA_W-1:0] wr_data;
  always_comb begin
    vs_fall = vs_prev_q & ~v_sync;
    wr_ok = state_q == ACCEPT && cpu_wr_req && !ack_q;
    in_range = cpu_wr_index <= LAST;
    state_d = state_q;
    front_sel_d = front_sel_q;
    frame_count_d = frame_count_q;
    ack_d = wr_ok;
    wr_error_d = wr_error_q | (wr_ok & ~in_range);
    wr_en = wr_ok & in_range & ~clr;
    wr_idx = cpu_wr_index;
    wr_data = {cpu_wr_distance, cpu_wr_texture};
    rd_d = gpu_read_index <= LAST ? mem[front_sel_q][gpu_read_index] : '0;
    if (state_q == ACCEPT && cpu_commit) state_d = SWAP_PENDING;
    if (state_q == SWAP_PENDING && vs_fall) begin
      front_sel_d = ~front_sel_q;
      frame_count_d = frame_count_q + 8'd1;
      state_d = POST_SWAP;
    end
`ifdef COLUMN_BUFFER_CLEAR_ON_SWAP_EN
    clr_idx_d = clr_idx_q;
    if (state_q == CLEARING) begin
      wr_en = ~clr;
      wr_idx = clr_idx_q;
      wr_data = {{DATA_W{1'b1}}, {DATA_W{1'b0}}};
      clr_idx_d = clr_idx_q == LAST ? '0 : clr_idx_q + 1'b1;
      state_d = clr_idx_q == LAST ? ACCEPT : CLEARING;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= RST_ST;
      front_sel_q <= 1'b0;
      ack_q <= 1'b0;
      wr_error_q <= 1'b0;
      frame_count_q <= 8'd0;
      vs_prev_q <= 1'b1;
      rd_q <= '0;
`ifdef COLUMN_BUFFER_CLEAR_ON_SWAP_EN
      clr_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      front_sel_q <= front_sel_d;
      ack_q <= ack_d;
      wr_error_q <= wr_error_d;
      frame_count_q <= frame_count_d;
      vs_prev_q <= v_sync;
      rd_q <= rd_d;
`ifdef COLUMN_BUFFER_CLEAR_ON_SWAP_EN
      clr_idx_q <= clr_idx_d;
`endif
    end
  end
  // Writes always target the back bank, so the GPU never sees a half-built frame.
  always_ff @(posedge clk) if (wr_en) mem[~front_sel_q][wr_idx] <= wr_data;
  assign cpu_wr_ack = ack_q;
  assign swap_pending = state_q == SWAP_PENDING;
  assign wr_error = wr_error_q;
  assign front_sel = front_sel_q;
  assign frame_count = frame_count_q;
  assign gpu_distance = rd_q[2*DATA_W-1:DATA_W];
  assign gpu_texture = rd_q[DATA_W-1:0];
endmodule

// File: doc/column_buffer_scheduler.md
Name: column_buffer_scheduler

Overview:
- Double-buffered column store that shares per-column wall data between the CPU (producer) and the GPU column pipeline (consumer).
- CPU writes {distance, texture} for each of 320 screen columns into the back bank through a req/ack handshake.
- GPU reads the front bank by column index.
- Banks swap only at vertical sync after the CPU commits, so a frame is never torn mid-scan.

Parameters:
- COLUMNS, 320, number of column entries per bank
- IDX_W, 9, column index width (must satisfy 2**IDX_W >= COLUMNS)
- DATA_W, 16, width of the distance field and of the texture field

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous reset, active-high
- cpu_wr_req  in  1  write request, held until cpu_wr_ack
- cpu_wr_index  in  IDX_W  column to write
- cpu_wr_distance  in  DATA_W  distance for the column
- cpu_wr_texture  in  DATA_W  texture word ([9:8] id, [5:0] u)
- cpu_wr_ack  out  1  one-cycle write acknowledge
- cpu_commit  in  1  one-cycle pulse: back bank complete, request swap
- swap_pending  out  1  high from commit until the swap occurs
- wr_error  out  1  sticky flag: an out-of-range write was acked
- v_sync  in  1  active-low vertical sync from the VGA controller
- gpu_read_index  in  IDX_W  column requested by the GPU
- gpu_distance  out  DATA_W  front-bank distance, 1-cycle latency
- gpu_texture  out  DATA_W  front-bank texture, 1-cycle latency
- front_sel  out  1  which bank is currently front
- frame_count  out  8  completed swaps, wraps 255->0

Behaviour:
- Reset (clr=1 at a clk edge):
  - state=ACCEPT; front_sel=0; cpu_wr_ack=0; swap_pending=0; wr_error=0; frame_count=0; gpu_distance=0; gpu_texture=0.
  - Internal v_sync history register is set to 1.
  - Bank RAM contents are not reset.
  - Reset mid-handshake drops any pending ack; the CPU must re-request.
- States: ACCEPT, SWAP_PENDING (plus CLEARING under the option).
- Write handshake, ACCEPT only:
  - A cpu_wr_req sampled high with ack low gives cpu_wr_ack=1 on the next cycle for exactly one cycle.
  - The entry is written into bank ~front_sel on that sampling edge.
  - The CPU drops req, or presents the next write, after it sees ack. A req still high in the ack cycle is not a new request.
  - Back-to-back writes therefore run at one write per 2 cycles.
- Index >= COLUMNS: acked normally, data discarded, wr_error set. wr_error clears only on clr.
- Commit:
  - cpu_commit in ACCEPT moves the block to SWAP_PENDING and sets swap_pending=1 on the next cycle.
  - Commit in the same cycle as a sampled write: the write is performed and acked, and the commit is honoured.
  - Commit in SWAP_PENDING is ignored.
- SWAP_PENDING: cpu_wr_req is stalled (no ack, no write) until the block returns to ACCEPT.
- Swap:
  - Falling edge of v_sync is detected as registered previous=1 and current=0.
  - In SWAP_PENDING, that edge toggles front_sel, increments frame_count, clears swap_pending and returns to ACCEPT, all on the same edge.
  - v_sync edges in ACCEPT have no effect; the front bank persists indefinitely.
- GPU read:
  - gpu_read_index is sampled every cycle; front-bank data appears on gpu_distance/gpu_texture next cycle.
  - Index >= COLUMNS returns 0 on both outputs.
  - A read sampled on the swap edge uses the old front_sel. Reads are never stalled.
- The CPU can never write the front bank; the GPU can never read the back bank.

Optional Feature:
- Macro: COLUMN_BUFFER_CLEAR_ON_SWAP_EN
- Defined:
  - After each swap, the block enters CLEARING instead of ACCEPT.
  - It writes distance=16'hFFFF (treated as "no wall") and texture=0 into the new back bank, one entry per cycle, index 0..COLUMNS-1.
  - It then enters ACCEPT. Clearing takes exactly COLUMNS cycles.
  - swap_pending stays 0 during CLEARING; CPU writes are stalled and commits are ignored.
  - Reset also enters CLEARING for bank 1 (the back bank out of reset).
- Not defined: no CLEARING state; the back bank retains the stale contents from two frames earlier.

Test Plan:
- Write index 5 (distance 16'h0040, texture 16'h0123); commit; drive v_sync 1->0 -> cpu_wr_ack pulses 1 cycle; swap_pending rises; at the edge front_sel=1 and frame_count=1; gpu_read_index=5 returns 16'h0040/16'h0123 one cycle later.
- Before commit, read index 5 -> returns old front data; the new value is invisible until the swap.
- Commit, then hold cpu_wr_req for 50 cycles before the v_sync fall -> no ack during that window; ack arrives the cycle after the swap; the write lands in the new back bank.
- Write index 320 -> ack pulses, wr_error=1, no bank entry changes; wr_error stays set until clr.
- Apply 256 commit+vsync cycles -> frame_count wraps to 0 and front_sel has toggled 256 times (ends at 0); v_sync edges without a commit leave both unchanged.
- With COLUMN_BUFFER_CLEAR_ON_SWAP_EN: after a swap, writes are stalled for exactly 320 cycles; the next swap with no CPU writes makes every index read 16'hFFFF/0. Assert clr mid-clear -> the clear restarts from index 0.
